// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the pe_mac_tile processing element:
//   - default operand / accumulator widths
//   - drain FSM state encoding
//   - width legality helper used for the elaboration-time check
// Optional build macro honoured by the PE: PE_ACC_SAT_EN (saturating
// accumulation plus the sat_flag port).
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int unsigned PE_DATA_W = 8;
  localparam int unsigned PE_ACC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_PASS = 2'd2
  } pe_state_e;

  // The accumulator must hold at least one full-width product.
  function automatic bit acc_w_fits(input int unsigned data_w, input int unsigned acc_w);
    return (acc_w >= (32'd2 * data_w));
  endfunction

endpackage

// File: rtl/pe_mac_tile_if.sv
// -----------------------------------------------------------------------------
// pe_mac_tile_if
// Bundles the operand streams, tile framing, result drain chain and status of
// one processing element.
//   master : the array / environment side (drives operands, drain window,
//            upstream result; observes forwarded operands and results)
//   slave  : the PE side
// Signals:
//   op_signed                          operand signedness per MAC
//   inp_west, w_valid, w_first, w_last west operand stream with tile framing
//   inp_north, n_valid                 north operand stream
//   outp_east, e_valid, e_first, e_last registered west stream toward east
//   outp_south, s_valid                registered north stream toward south
//   drain_en                           column drain window
//   res_in, res_in_valid               result from the northern neighbour
//   res_out, res_out_valid             result toward the south
//   ovf_err                            sticky overwrite-before-drain error
// -----------------------------------------------------------------------------
interface pe_mac_tile_if
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ACC_W  = PE_ACC_W
);

  logic              op_signed;
  logic [DATA_W-1:0] inp_west;
  logic              w_valid;
  logic              w_first;
  logic              w_last;
  logic [DATA_W-1:0] inp_north;
  logic              n_valid;
  logic [DATA_W-1:0] outp_east;
  logic              e_valid;
  logic              e_first;
  logic              e_last;
  logic [DATA_W-1:0] outp_south;
  logic              s_valid;
  logic              drain_en;
  logic [ACC_W-1:0]  res_in;
  logic              res_in_valid;
  logic [ACC_W-1:0]  res_out;
  logic              res_out_valid;
  logic              ovf_err;

  modport master (
    output op_signed, inp_west, w_valid, w_first, w_last, inp_north, n_valid,
           drain_en, res_in, res_in_valid,
    input  outp_east, e_valid, e_first, e_last, outp_south, s_valid,
           res_out, res_out_valid, ovf_err
  );

  modport slave (
    input  op_signed, inp_west, w_valid, w_first, w_last, inp_north, n_valid,
           drain_en, res_in, res_in_valid,
    output outp_east, e_valid, e_first, e_last, outp_south, s_valid,
           res_out, res_out_valid, ovf_err
  );

endinterface

// File: rtl/pe_mac_unit.sv
// -----------------------------------------------------------------------------
// pe_mac_unit
// Combinational multiply-accumulate step of the PE.
//   op_signed  in  1       operands two's-complement when 1
//   north      in  DATA_W  north operand
//   west       in  DATA_W  west operand
//   acc_in     in  ACC_W   current accumulator
//   first      in  1       start of tile: product replaces the accumulator
//   sum        out ACC_W   next accumulator value
//   sat        out 1       (PE_ACC_SAT_EN only) result was clamped
// Build macro PE_ACC_SAT_EN: clamp at the ACC_W limits instead of wrapping.
// -----------------------------------------------------------------------------
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ACC_W  = PE_ACC_W
) (
  input  logic              op_signed,
  input  logic [DATA_W-1:0] north,
  input  logic [DATA_W-1:0] west,
  input  logic [ACC_W-1:0]  acc_in,
  input  logic              first,
`ifdef PE_ACC_SAT_EN
  output logic              sat,
`endif
  output logic [ACC_W-1:0]  sum
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_sgn_s;
  logic        [PROD_W-1:0] prod_uns_s;
  logic        [ACC_W-1:0]  prod_ext_s;
  logic        [ACC_W-1:0]  base_s;

  // Both products are formed at full width; size casts of a signed operand
  // sign-extend, of an unsigned one zero-extend.
  assign prod_sgn_s = PROD_W'($signed(north)) * PROD_W'($signed(west));
  assign prod_uns_s = PROD_W'(north) * PROD_W'(west);
  assign prod_ext_s = op_signed ? ACC_W'(prod_sgn_s) : ACC_W'(prod_uns_s);
  assign base_s     = first ? {ACC_W{1'b0}} : acc_in;

`ifdef PE_ACC_SAT_EN
  logic [ACC_W:0] sum_wide_s;

  assign sum_wide_s = {1'b0, base_s} + {1'b0, prod_ext_s};

  // Clamp: signed overflow when both addends share a sign the result lost;
  // unsigned overflow is a carry out (unsigned products are never negative).
  always_comb begin
    sum = sum_wide_s[ACC_W-1:0];
    sat = 1'b0;
    if (op_signed) begin
      if ((base_s[ACC_W-1] == prod_ext_s[ACC_W-1]) &&
          (sum_wide_s[ACC_W-1] != prod_ext_s[ACC_W-1])) begin
        sat = 1'b1;
        sum = prod_ext_s[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        sat = 1'b0;
      end
    end else begin
      if (sum_wide_s[ACC_W]) begin
        sat = 1'b1;
        sum = {ACC_W{1'b1}};
      end else begin
        sat = 1'b0;
      end
    end
  end
`else
  assign sum = base_s + prod_ext_s;
`endif

endmodule

// File: rtl/pe_mac_tile.sv
// -----------------------------------------------------------------------------
// pe_mac_tile
// Output-stationary systolic processing element with tile framing and a
// south-bound result drain chain.
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-low reset
//   bus      slave modport of pe_mac_tile_if (operands, framing, forwarding,
//            drain chain, ovf_err)
//   sat_flag out  (PE_ACC_SAT_EN only) one-cycle pulse on a clamped MAC
// Operands and framing are forwarded east/south with one cycle of latency.
// A tile's final sum is parked in a hold register and emitted into the drain
// chain when drain_en is seen; while draining, the PE passes its northern
// neighbour's results south so the southmost PE's result leaves first.
// Build macro PE_ACC_SAT_EN: saturating accumulation and the sat_flag port.
// -----------------------------------------------------------------------------
module pe_mac_tile
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ACC_W  = PE_ACC_W
) (
  input  logic         clk,
  input  logic         rst,
`ifdef PE_ACC_SAT_EN
  output logic         sat_flag,
`endif
  pe_mac_tile_if.slave bus
);

  if (!acc_w_fits(DATA_W, ACC_W)) begin : g_acc_w_check
    $error("pe_mac_tile: ACC_W must be at least 2*DATA_W");
  end

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] hold_r;
  logic             hold_full_r;
  pe_state_e        state_r;

  logic             fire_s;
  logic             complete_s;
  logic [ACC_W-1:0] mac_sum_s;
`ifdef PE_ACC_SAT_EN
  logic             mac_sat_s;
`endif

  assign fire_s     = bus.w_valid & bus.n_valid;
  assign complete_s = fire_s & bus.w_last;

  pe_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .op_signed (bus.op_signed),
    .north     (bus.inp_north),
    .west      (bus.inp_west),
    .acc_in    (acc_r),
    .first     (bus.w_first),
`ifdef PE_ACC_SAT_EN
    .sat       (mac_sat_s),
`endif
    .sum       (mac_sum_s)
  );

  // Operand forwarding (unconditional, even when invalid) and accumulator.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.outp_east  <= {DATA_W{1'b0}};
      bus.e_valid    <= 1'b0;
      bus.e_first    <= 1'b0;
      bus.e_last     <= 1'b0;
      bus.outp_south <= {DATA_W{1'b0}};
      bus.s_valid    <= 1'b0;
      acc_r          <= {ACC_W{1'b0}};
    end else begin
      bus.outp_east  <= bus.inp_west;
      bus.e_valid    <= bus.w_valid;
      bus.e_first    <= bus.w_first;
      bus.e_last     <= bus.w_last;
      bus.outp_south <= bus.inp_north;
      bus.s_valid    <= bus.n_valid;
      if (fire_s) begin
        acc_r <= mac_sum_s;
      end
    end
  end

`ifdef PE_ACC_SAT_EN
  // One-cycle pulse for every MAC whose result was clamped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_flag <= 1'b0;
    end else begin
      sat_flag <= fire_s & mac_sat_s;
    end
  end
`endif

  // Drain FSM: parks finished results and drives the south-bound result chain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r           <= ST_IDLE;
      hold_r            <= {ACC_W{1'b0}};
      hold_full_r       <= 1'b0;
      bus.res_out       <= {ACC_W{1'b0}};
      bus.res_out_valid <= 1'b0;
      bus.ovf_err       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bus.res_out_valid <= 1'b0;
          if (complete_s) begin
            hold_r      <= mac_sum_s;
            hold_full_r <= 1'b1;
            state_r     <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (bus.drain_en) begin
            bus.res_out       <= hold_r;
            bus.res_out_valid <= 1'b1;
            // A result landing in the emit cycle replaces the one leaving, so
            // nothing is lost and this PE must still wait for its own slot.
            if (complete_s) begin
              hold_r      <= mac_sum_s;
              hold_full_r <= 1'b1;
              state_r     <= ST_HELD;
            end else begin
              hold_full_r <= 1'b0;
              state_r     <= ST_PASS;
            end
          end else begin
            bus.res_out_valid <= 1'b0;
            if (complete_s) begin
              hold_r      <= mac_sum_s;
              bus.ovf_err <= 1'b1;
            end
          end
        end
        ST_PASS: begin
          bus.res_out       <= bus.res_in;
          bus.res_out_valid <= bus.res_in_valid;
          if (complete_s) begin
            hold_r      <= mac_sum_s;
            hold_full_r <= 1'b1;
            if (hold_full_r) begin
              bus.ovf_err <= 1'b1;
            end
          end
          // A result parked during the window is emitted in the next window.
          if (!bus.drain_en) begin
            state_r <= (complete_s || hold_full_r) ? ST_HELD : ST_IDLE;
          end
        end
        default: begin
          bus.res_out_valid <= 1'b0;
          hold_full_r       <= 1'b0;
          state_r           <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_tile.sv
module tb_pe_mac_tile;
  import pe_pkg::*;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int SW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  pe_mac_tile_if #(.DATA_W(DW), .ACC_W(AW)) bus ();
  pe_mac_tile_if #(.DATA_W(DW), .ACC_W(SW)) sbus ();
  pe_mac_tile_if #(.DATA_W(DW), .ACC_W(AW)) c0 ();
  pe_mac_tile_if #(.DATA_W(DW), .ACC_W(AW)) c1 ();
  pe_mac_tile_if #(.DATA_W(DW), .ACC_W(AW)) c2 ();
  pe_mac_tile_if #(.DATA_W(DW), .ACC_W(AW)) c3 ();

`ifdef PE_ACC_SAT_EN
  logic sat_m, sat_s, sat_c0, sat_c1, sat_c2, sat_c3;
`endif

  pe_mac_tile #(.DATA_W(DW), .ACC_W(AW)) u_main (.clk(clk), .rst(rst),
`ifdef PE_ACC_SAT_EN
    .sat_flag(sat_m),
`endif
    .bus(bus));
  pe_mac_tile #(.DATA_W(DW), .ACC_W(SW)) u_sat (.clk(clk), .rst(rst),
`ifdef PE_ACC_SAT_EN
    .sat_flag(sat_s),
`endif
    .bus(sbus));
  pe_mac_tile #(.DATA_W(DW), .ACC_W(AW)) u_c0 (.clk(clk), .rst(rst),
`ifdef PE_ACC_SAT_EN
    .sat_flag(sat_c0),
`endif
    .bus(c0));
  pe_mac_tile #(.DATA_W(DW), .ACC_W(AW)) u_c1 (.clk(clk), .rst(rst),
`ifdef PE_ACC_SAT_EN
    .sat_flag(sat_c1),
`endif
    .bus(c1));
  pe_mac_tile #(.DATA_W(DW), .ACC_W(AW)) u_c2 (.clk(clk), .rst(rst),
`ifdef PE_ACC_SAT_EN
    .sat_flag(sat_c2),
`endif
    .bus(c2));
  pe_mac_tile #(.DATA_W(DW), .ACC_W(AW)) u_c3 (.clk(clk), .rst(rst),
`ifdef PE_ACC_SAT_EN
    .sat_flag(sat_c3),
`endif
    .bus(c3));

  // Result chain of the column: c0 is northmost, c3 southmost.
  assign c1.res_in       = c0.res_out;
  assign c1.res_in_valid = c0.res_out_valid;
  assign c2.res_in       = c1.res_out;
  assign c2.res_in_valid = c1.res_out_valid;
  assign c3.res_in       = c2.res_out;
  assign c3.res_in_valid = c2.res_out_valid;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];
  exp_t q_col[$];

  // Reference model state for the main PE (tile-level view).
  longint      acc_m;
  logic [31:0] pend_val;
  bit          pend_v, win, ovf_m;

  logic [2*DW+4:0] fx;
  logic            ovf_q;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected forwarded operands and sticky error, captured at the active edge.
  always @(posedge clk) begin
    if (!rst) fx <= '0;
    else fx <= {bus.inp_west, bus.w_valid, bus.w_first, bus.w_last, bus.inp_north, bus.n_valid};
    ovf_q <= ovf_m;
  end

  // Monitor: compares forwarding every cycle and pops the scoreboards on valid.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("fwd", {bus.outp_east, bus.e_valid, bus.e_first, bus.e_last, bus.outp_south, bus.s_valid}, fx);
      chk("ovf_err", bus.ovf_err, ovf_q);
      if (bus.res_out_valid) begin
        if (q_main.size() == 0) chk("main_extra_valid", bus.res_out_valid, 1'b0);
        else begin
          e = q_main.pop_front();
          chk("main_res", bus.res_out, e.val);
          chk("main_lat", cyc, e.due);
        end
      end
      if (sbus.res_out_valid) begin
        if (q_sat.size() == 0) chk("sat_extra_valid", sbus.res_out_valid, 1'b0);
        else begin
          e = q_sat.pop_front();
          chk("sat_res", sbus.res_out, e.val);
          chk("sat_lat", cyc, e.due);
        end
      end
      if (c3.res_out_valid) begin
        if (q_col.size() == 0) chk("col_extra_valid", c3.res_out_valid, 1'b0);
        else begin
          e = q_col.pop_front();
          chk("col_res", c3.res_out, e.val);
          chk("col_lat", cyc, e.due);
        end
      end
    end
  end

  // One clock of stimulus on the main PE, with the reference model stepped.
  task automatic mstep(input logic [7:0] n, input logic [7:0] w, input logic nv, input logic wv,
                       input logic f, input logic l, input logic d, input logic s);
    longint p;
    bit     emitted;
    bus.inp_north = n; bus.inp_west = w; bus.n_valid = nv; bus.w_valid = wv;
    bus.w_first = f; bus.w_last = l; bus.drain_en = d; bus.op_signed = s;
    bus.res_in = $urandom; bus.res_in_valid = 1'b0;
    if (!rst) begin
      acc_m = 0; pend_v = 0; win = 0; ovf_m = 0;
    end else begin
      emitted = 0;
      if (d && pend_v && !win) begin
        q_main.push_back('{pend_val, cyc + 1});
        pend_v = 0; win = 1; emitted = 1;
      end
      if (!d) win = 0;
      if (nv && wv) begin
        p = s ? longint'($signed(n)) * longint'($signed(w)) : longint'(n) * longint'(w);
        acc_m = f ? p : acc_m + p;
        if (l) begin
          if (pend_v) ovf_m = 1;
          pend_v = 1;
          pend_val = acc_m[31:0];
          if (emitted) win = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic midle();
    mstep(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mdrain();
    mstep(8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle_if_sbus();
    sbus.op_signed = 1'b0; sbus.inp_west = '0; sbus.w_valid = 1'b0; sbus.w_first = 1'b0;
    sbus.w_last = 1'b0; sbus.inp_north = '0; sbus.n_valid = 1'b0; sbus.drain_en = 1'b0;
    sbus.res_in = '0; sbus.res_in_valid = 1'b0;
  endtask

  task automatic col_set(input logic v, input logic d);
    c0.inp_north = 8'd10; c1.inp_north = 8'd20; c2.inp_north = 8'd30; c3.inp_north = 8'd40;
    c0.inp_west = 8'd10; c1.inp_west = 8'd10; c2.inp_west = 8'd10; c3.inp_west = 8'd10;
    {c0.w_valid, c1.w_valid, c2.w_valid, c3.w_valid} = {4{v}};
    {c0.n_valid, c1.n_valid, c2.n_valid, c3.n_valid} = {4{v}};
    {c0.w_first, c1.w_first, c2.w_first, c3.w_first} = {4{v}};
    {c0.w_last, c1.w_last, c2.w_last, c3.w_last} = {4{v}};
    {c0.drain_en, c1.drain_en, c2.drain_en, c3.drain_en} = {4{d}};
    {c0.op_signed, c1.op_signed, c2.op_signed, c3.op_signed} = 4'b0;
    c0.res_in = '0; c0.res_in_valid = 1'b0;
  endtask

  initial begin
    int          sa;
    logic [15:0] sat_exp;
    logic        s;
    int          len, k;
    rst = 1'b0;
    idle_if_sbus();
    col_set(1'b0, 1'b0);
    midle(); midle();
    rst = 1'b1;
    mon_en = 1'b1;
    chk("rst_res_out", bus.res_out, 32'd0);
    chk("rst_res_valid", bus.res_out_valid, 1'b0);

    // Unsigned 3-term tile.
    mstep(8'd200, 8'd255, 1, 1, 1, 0, 0, 0);
    mstep(8'd1, 8'd1, 1, 1, 0, 0, 0, 0);
    mstep(8'd10, 8'd10, 1, 1, 0, 1, 0, 0);
    midle();
    mdrain();
    chk("tp_unsigned", bus.res_out, 32'd51101);
    midle();

    // Signed 1-term tiles.
    mstep(8'h80, 8'h80, 1, 1, 1, 1, 0, 1);
    mdrain();
    chk("tp_signed_a", bus.res_out, 32'd16384);
    midle();
    mstep(8'hFD, 8'h05, 1, 1, 1, 1, 0, 1);
    mdrain();
    chk("tp_signed_b", bus.res_out, 32'hFFFF_FFF1);
    midle();

    // Completion in the same cycle as the drain of an older result.
    mstep(8'd3, 8'd4, 1, 1, 1, 1, 0, 0);
    mstep(8'd5, 8'd6, 1, 1, 1, 1, 1, 0);
    mdrain();
    midle();

    // Bubbles between pairs: single-sided valids must not fire.
    mstep(8'd2, 8'd2, 1, 1, 1, 0, 0, 0);
    mstep(8'd99, 8'd99, 1, 0, 0, 1, 0, 0);
    mstep(8'd99, 8'd99, 0, 1, 1, 1, 0, 0);
    mstep(8'd3, 8'd3, 1, 1, 0, 1, 0, 0);
    mdrain();
    midle();

    // Sat / wrap tile on the 16-bit PE (signed 127*127 three times).
    sa = 0;
    for (int i = 0; i < 3; i++) begin
      sa = sa + 127 * 127;
`ifdef PE_ACC_SAT_EN
      if (sa > 32767) sa = 32767;
`else
      sa = int'(16'(sa));
`endif
    end
    sat_exp = 16'(sa);
    for (int i = 0; i < 3; i++) begin
      sbus.inp_north = 8'd127; sbus.inp_west = 8'd127; sbus.op_signed = 1'b1;
      sbus.w_valid = 1'b1; sbus.n_valid = 1'b1;
      sbus.w_first = (i == 0); sbus.w_last = (i == 2);
      midle();
`ifdef PE_ACC_SAT_EN
      chk("sat_flag_pulse", sat_s, (i == 2) ? 1'b1 : 1'b0);
`endif
    end
    idle_if_sbus();
    midle();
`ifdef PE_ACC_SAT_EN
    chk("sat_flag_clear", sat_s, 1'b0);
`endif
    q_sat.push_back('{{16'd0, sat_exp}, cyc + 1});
    sbus.drain_en = 1'b1;
    midle();
`ifdef PE_ACC_SAT_EN
    chk("tp_sat", sbus.res_out, 16'd32767);
`else
    chk("tp_wrap", sbus.res_out, 16'hBD03);
`endif
    idle_if_sbus();
    midle();

    // 4-PE column: each holds k*100, southmost (400) leaves first.
    col_set(1'b1, 1'b0);
    midle();
    col_set(1'b0, 1'b0);
    midle();
    for (int i = 3; i >= 0; i--) q_col.push_back('{32'((i + 1) * 100), cyc + 1 + (3 - i)});
    col_set(1'b0, 1'b1);
    repeat (4) midle();
    col_set(1'b0, 1'b0);
    repeat (3) midle();

    // Overflow: two tiles without drain, then a drain shows the newer one.
    mstep(8'd11, 8'd11, 1, 1, 1, 1, 0, 0);
    mstep(8'd12, 8'd12, 1, 1, 1, 1, 0, 0);
    midle();
    chk("tp_ovf_set", bus.ovf_err, 1'b1);
    mdrain();
    chk("tp_ovf_newer", bus.res_out, 32'd144);
    midle(); midle();
    chk("tp_ovf_sticky", bus.ovf_err, 1'b1);

    // Randomised tiles with random bubbles and drain windows.
    for (int t = 0; t < 40; t++) begin
      s = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          k = $urandom_range(0, 2);
          mstep(8'($urandom), 8'($urandom), k == 1, k == 2, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, s);
        end
        mstep(8'($urandom), 8'($urandom), 1, 1, i == 0, i == len - 1, $urandom_range(0, 2) == 0, s);
      end
      repeat ($urandom_range(0, 2)) mstep(8'd0, 8'd0, 0, 0, 0, 0, $urandom_range(0, 1) == 1, 0);
    end
    midle(); mdrain(); midle(); mdrain(); midle(); midle();

    // Reset mid-tile; next tile accumulates from a cleared accumulator.
    mstep(8'd9, 8'd9, 1, 1, 1, 0, 0, 0);
    rst = 1'b0;
    mstep(8'd9, 8'd9, 1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    chk("rst_mid_res", bus.res_out, 32'd0);
    chk("rst_mid_valid", bus.res_out_valid, 1'b0);
    chk("rst_mid_ovf", bus.ovf_err, 1'b0);
    mstep(8'd7, 8'd6, 1, 1, 0, 1, 0, 0);
    mdrain();
    chk("tp_after_rst", bus.res_out, 32'd42);
    midle();

    // Reset in the drain cycle discards the held result.
    mstep(8'd8, 8'd8, 1, 1, 1, 1, 0, 0);
    rst = 1'b0;
    mdrain();
    rst = 1'b1;
    mdrain();
    midle(); midle();
    chk("rst_drain_valid", bus.res_out_valid, 1'b0);

    chk("main_q_empty", q_main.size(), 0);
    chk("sat_q_empty", q_sat.size(), 0);
    chk("col_q_empty", q_col.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pe_mac_tile.md
Name: pe_mac_tile

Overview:
- Parametrised output-stationary systolic processing element; next generation of the 8-bit unsigned MAC cell.
- Adds configurable operand and accumulator widths, a signed/unsigned mode, and valid/first/last framing so one PE computes back-to-back tiles.
- Adds a result drain chain: finished results shift south through the column with no array-wide stall.
- Instantiated N×M inside the array top. Operands flow west→east and north→south; results drain north→south.

Parameters:
- DATA_W, 8, operand width (north and west).
- ACC_W, 32, accumulator/result width; must be ≥ 2*DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- op_signed  in  1  1 = operands two's-complement, 0 = unsigned; sampled with each MAC.
- inp_west  in  DATA_W  west operand.
- w_valid  in  1  inp_west valid.
- w_first  in  1  first pair of tile (qualified by w_valid).
- w_last  in  1  last pair of tile (qualified by w_valid).
- inp_north  in  DATA_W  north operand.
- n_valid  in  1  inp_north valid.
- outp_east  out  DATA_W  registered inp_west.
- e_valid, e_first, e_last  out  1 each  registered w_valid/w_first/w_last.
- outp_south  out  DATA_W  registered inp_north.
- s_valid  out  1  registered n_valid.
- drain_en  in  1  column drain window (broadcast).
- res_in  in  ACC_W  result from north neighbour's res_out.
- res_in_valid  in  1  res_in valid.
- res_out  out  ACC_W  result toward south.
- res_out_valid  out  1  res_out valid.
- ovf_err  out  1  sticky: held result overwritten before drain.

Behaviour:
- Reset (rst=0 at clk edge): every output, the accumulator, the hold register and the FSM clear to 0 / IDLE. Reset mid-tile or mid-drain discards all data.
- Forwarding: every clock, outp_east, the e_* flags, outp_south and s_valid take their inputs. Latency 1 cycle, unconditional, data passed even when invalid.
- Fire condition: fire = w_valid & n_valid. Product = inp_north*inp_west, 2*DATA_W bits, signed or unsigned per op_signed, then sign- or zero-extended to ACC_W.
- Accumulate on fire: acc <= w_first ? product : acc + product. No fire: acc holds. Default arithmetic wraps mod 2^ACC_W.
- Completion on fire & w_last: the final value (acc + product, or product if w_first is also set) is loaded into hold next edge. first & last in one pair gives a 1-term tile.
- Drain FSM, states IDLE / HELD / PASS:
  - IDLE: a completion goes to HELD. res_out_valid=0.
  - HELD with drain_en=1: res_out<=hold, res_out_valid<=1, go to PASS. Held result appears 1 cycle after drain_en is seen.
  - HELD with drain_en=0: wait.
  - PASS: res_out<=res_in, res_out_valid<=res_in_valid. drain_en=0 goes to IDLE.
- Overlapping events:
  - Completion in HELD: hold overwritten, ovf_err<=1 (sticky until reset), stay HELD.
  - Completion in HELD in the same cycle as drain_en: the old hold is emitted, the new value is loaded, next state HELD (not PASS).
  - Completion in PASS: hold loaded, forwarding continues; on drain_en fall go to HELD instead of IDLE.
- Column drain order: the southmost PE emits first. A column of R PEs needs drain_en held ≥ R cycles.

Optional Feature:
- Macro PE_ACC_SAT_EN.
- Defined: accumulation saturates at ACC_W limits (signed limits when op_signed=1, 0..2^ACC_W-1 when unsigned). Port sat_flag out 1 pulses for one cycle on any clamped fire.
- Undefined: wrap-around arithmetic; sat_flag port absent.

Decomposition:
- Package pe_pkg: FSM state enum (IDLE, HELD, PASS), default DATA_W/ACC_W constants, ACC_W ≥ 2*DATA_W elaboration check.
- Sub-module pe_mac_unit: combinational signed/unsigned multiply with extend, plus the add / optional saturation. pe_mac_tile holds all registers and the FSM.

Test Plan:
- Unsigned 3-term tile: (north,west)=(200,255),(1,1),(10,10) with first on 1st, last on 3rd, op_signed=0 → hold=51101, FSM HELD; drain_en → res_out=51101, valid 1 cycle later.
- Signed 1-term tile (first & last together), DATA_W=8: (-128,-128) → hold=16384; (-3,5) next tile → hold=-15 sign-extended.
- Back-to-back tiles without drain → second value in hold, ovf_err=1 and stays 1 through a later drain until rst=0.
- 4-PE column, each holding k*100, drain_en for 4 cycles → bottom res_out sequence 400,300,200,100 on consecutive cycles with valid high.
- rst=0 asserted mid-tile and mid-drain → next cycle all outputs 0, FSM IDLE; a following new tile accumulates from scratch.
- With PE_ACC_SAT_EN defined, ACC_W=16, signed: accumulate 127*127 three times → clamps at 32767, sat_flag pulses; without the macro, wraps to -17149.
